// File: rtl/sdram_port_arbiter.sv
// CPU/DMA arbiter onto a single-port SDRAM request bus, one access per sync-aligned slot.
// Optional build macro STARVE_GUARD_EN: force a pending DMA grant after MAX_WAIT straight CPU grants.
module sdram_port_arbiter #(
  parameter int SLOT_LEN   = 8,
  parameter int RD_LATENCY = 6,
  parameter int MAX_WAIT   = 4
) (
  input  logic        clk_sys,
  input  logic        RESET_N,
  input  logic        sync,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [24:0] cpu_addr,
  input  logic [15:0] cpu_din,
  input  logic [1:0]  cpu_ds,
  output logic        cpu_ack,
  output logic [15:0] cpu_dout,
  input  logic        dma_req,
  input  logic        dma_we,
  input  logic [24:0] dma_addr,
  input  logic [15:0] dma_din,
  input  logic [1:0]  dma_ds,
  output logic        dma_ack,
  output logic [15:0] dma_dout,
  output logic [24:0] sdram_addr,
  output logic [15:0] sdram_din,
  output logic [1:0]  sdram_ds,
  output logic        sdram_we,
  output logic        sdram_oe,
  input  logic [15:0] sdram_out
);
  localparam int            CW       = (SLOT_LEN > 1) ? $clog2(SLOT_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_LEN - 1);
  localparam logic [CW-1:0] CNT_RD   = CW'(RD_LATENCY);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] BUSY = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  if (RD_LATENCY >= SLOT_LEN || MAX_WAIT < 1 || MAX_WAIT > 7) begin : g_bad_params
    $error("sdram_port_arbiter: RD_LATENCY must be < SLOT_LEN and MAX_WAIT in 1..7");
  end

  logic [1:0]    state;
  logic [CW-1:0] slot_cnt;
  logic          rst_meta;
  logic          rst_sync;
  logic          grant_dma;
  logic          req_we;
  logic [24:0]   req_addr;
  logic [15:0]   req_din;
  logic [1:0]    req_ds;
  logic          arbitrate;
  logic          force_dma;
  logic          pick_dma;

  assign arbitrate = (state == IDLE) && rst_sync && (cpu_req || dma_req);
  assign pick_dma  = force_dma || !cpu_req;

  // The request registers only change in IDLE, so the bus is stable for the whole slot.
  assign sdram_addr = req_addr;
  assign sdram_din  = req_din;
  assign sdram_ds   = req_ds;

  // Reset asserts asynchronously but releases through two flops before arbitration resumes.
  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      rst_meta <= 1'b0;
      rst_sync <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
      rst_meta <= 1'b1;
      rst_sync <= rst_meta;
    end
  end

`ifdef STARVE_GUARD_EN
  logic [2:0] wait_cnt;

  assign force_dma = dma_req && (wait_cnt == 3'(MAX_WAIT));

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      wait_cnt <= 3'd0;
    end else if (arbitrate) begin
      if (pick_dma || !dma_req) begin
        wait_cnt <= 3'd0;
      end else if (wait_cnt != 3'd7) begin
        wait_cnt <= wait_cnt + 3'd1;
      end
    end
  end
`else
  assign force_dma = 1'b0;
`endif

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= IDLE;
      slot_cnt  <= '0;
      grant_dma <= 1'b0;
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_din   <= '0;
      req_ds    <= '0;
      sdram_we  <= 1'b0;
      sdram_oe  <= 1'b0;
      cpu_ack   <= 1'b0;
      dma_ack   <= 1'b0;
      cpu_dout  <= '0;
      dma_dout  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (arbitrate) begin
            grant_dma <= pick_dma;
            req_we    <= pick_dma ? dma_we   : cpu_we;
            req_addr  <= pick_dma ? dma_addr : cpu_addr;
            req_din   <= pick_dma ? dma_din  : cpu_din;
            req_ds    <= pick_dma ? dma_ds   : cpu_ds;
            state     <= ARM;
          end
        end
        ARM: begin
          if (sync) begin
            sdram_we <= req_we;
            sdram_oe <= !req_we;
            slot_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (slot_cnt == CNT_RD && !req_we) begin
            if (grant_dma) dma_dout <= sdram_out;
            else           cpu_dout <= sdram_out;
          end
          if (slot_cnt == CNT_LAST) begin
            sdram_we <= 1'b0;
            sdram_oe <= 1'b0;
            cpu_ack  <= !grant_dma;
            dma_ack  <= grant_dma;
            state    <= DONE;
          end else begin
            slot_cnt <= slot_cnt + CW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: expected accesses queued at issue, checked at slot and ack.
// Build with +define+STARVE_GUARD_EN to exercise the forced-DMA variant.
module tb_sdram_port_arbiter;
  localparam int SLOT_LEN    = 8;
  localparam int RD_LATENCY  = 6;
  localparam int MAX_WAIT    = 4;
  localparam int SYNC_PERIOD = 12;
`ifdef STARVE_GUARD_EN
  localparam int T4_BEFORE    = MAX_WAIT;
  localparam int T4_CPU_TOTAL = MAX_WAIT + 2;
`else
  localparam int T4_BEFORE    = 22;
  localparam int T4_CPU_TOTAL = 22;
`endif

  logic        clk_sys, RESET_N, sync;
  logic        cpu_req, cpu_we, cpu_ack;
  logic [24:0] cpu_addr;
  logic [15:0] cpu_din, cpu_dout;
  logic [1:0]  cpu_ds;
  logic        dma_req, dma_we, dma_ack;
  logic [24:0] dma_addr;
  logic [15:0] dma_din, dma_dout;
  logic [1:0]  dma_ds;
  logic [24:0] sdram_addr;
  logic [15:0] sdram_din, sdram_out;
  logic [1:0]  sdram_ds;
  logic        sdram_we, sdram_oe;

  sdram_port_arbiter #(.SLOT_LEN(SLOT_LEN), .RD_LATENCY(RD_LATENCY), .MAX_WAIT(MAX_WAIT)) dut (
    .clk_sys(clk_sys), .RESET_N(RESET_N), .sync(sync),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_ds(cpu_ds),
    .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_din(dma_din), .dma_ds(dma_ds),
    .dma_ack(dma_ack), .dma_dout(dma_dout),
    .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_ds(sdram_ds),
    .sdram_we(sdram_we), .sdram_oe(sdram_oe), .sdram_out(sdram_out)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic        port;  // 0=CPU, 1=DMA
    logic        we;
    logic [24:0] addr;
    logic [15:0] din;
    logic [1:0]  ds;
    logic [15:0] rdata;
  } acc_t;

  int          checks = 0;
  int          errors = 0;
  acc_t        exp_q[$];
  acc_t        ack_q[$];
  acc_t        cur;
  logic        in_slot;
  int          slot_idx;
  logic [44:0] snap;
  logic [15:0] cpu_dout_exp, dma_dout_exp;
  logic [15:0] cpu_rdata, dma_rdata;
  int          cpu_acks, cpu_acks_at_dma, cpu_left, dma_left, cyc;
  logic        sync_all;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [44:0] bus();
    return {sdram_addr, sdram_din, sdram_ds, sdram_we, sdram_oe};
  endfunction

  function automatic logic [33:0] port_outs();
    return {cpu_ack, cpu_dout, dma_ack, dma_dout};
  endfunction

  function automatic acc_t mk_acc(input logic port);
    acc_t a;
    a.port  = port;
    a.we    = port ? dma_we    : cpu_we;
    a.addr  = port ? dma_addr  : cpu_addr;
    a.din   = port ? dma_din   : cpu_din;
    a.ds    = port ? dma_ds    : cpu_ds;
    a.rdata = port ? dma_rdata : cpu_rdata;
    return a;
  endfunction

  // One clock of bench time: monitor the slot/ack at the falling edge, then drive the next cycle.
  task automatic step();
    acc_t a;
    @(negedge clk_sys);
    cyc++;
    if ((sdram_oe || sdram_we) && !in_slot) begin
      check("start_on_sync", sync, 1);
      check("start_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) cur = exp_q.pop_front();
      check("start_bus", bus(), {cur.addr, cur.din, cur.ds, cur.we, !cur.we});
      in_slot  = 1'b1;
      slot_idx = 0;
      snap     = bus();
    end else if (sdram_oe || sdram_we) begin
      slot_idx++;
      check("bus_stable", bus(), snap);
    end else if (in_slot) begin
      in_slot = 1'b0;
      check("slot_len", slot_idx + 1, SLOT_LEN);
      check("ack_after_slot", cpu_ack | dma_ack, 1);
      ack_q.push_back(cur);
    end
    check("ack_exclusive", cpu_ack & dma_ack, 0);
    if (cpu_ack || dma_ack) begin
      check("ack_expected", ack_q.size() != 0, 1);
      if (ack_q.size() != 0) begin
        a = ack_q.pop_front();
        check("ack_port", dma_ack, a.port);
        if (!a.we) begin
          if (a.port) dma_dout_exp = a.rdata;
          else        cpu_dout_exp = a.rdata;
        end
      end
      check("cpu_dout", cpu_dout, cpu_dout_exp);
      check("dma_dout", dma_dout, dma_dout_exp);
      if (cpu_ack) begin
        cpu_acks++;
        if (cpu_left > 0) cpu_left--;
        if (cpu_left == 0) cpu_req = 1'b0;
      end
      if (dma_ack) begin
        cpu_acks_at_dma = cpu_acks;
        if (dma_left > 0) dma_left--;
        if (dma_left == 0) dma_req = 1'b0;
      end
    end
    sync      = (sync_all && in_slot) || (cyc % SYNC_PERIOD == 0);
    sdram_out = (in_slot && slot_idx == RD_LATENCY && !cur.we) ? cur.rdata : 16'h0BAD;
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || ack_q.size() != 0 || in_slot || cpu_req || dma_req) && n < budget) begin
      step();
      n++;
    end
    check("idle_within_budget", n < budget, 1);
  endtask

  initial begin
    int n;
    RESET_N = 1'b0; sync = 1'b0; sdram_out = 16'h0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0; cpu_ds = '0;
    dma_req = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_din = '0; dma_ds = '0;
    cpu_rdata = '0; dma_rdata = '0; cpu_dout_exp = '0; dma_dout_exp = '0;
    in_slot = 1'b0; slot_idx = 0; snap = '0; cur = '0; sync_all = 1'b0;
    cpu_acks = 0; cpu_acks_at_dma = 0; cpu_left = 0; dma_left = 0; cyc = 0;

    repeat (3) step();
    check("reset_bus", bus(), 0);
    check("reset_ports", port_outs(), 0);
    RESET_N = 1'b1;
    repeat (4) step();
    check("idle_bus", bus(), 0);

    // 1: CPU read
    cpu_we = 1'b0; cpu_addr = 25'h0100000; cpu_din = 16'h0000; cpu_ds = 2'b11; cpu_rdata = 16'hBEEF;
    cpu_left = 1; cpu_req = 1'b1; exp_q.push_back(mk_acc(1'b0));
    run_until_idle(200);
    check("t1_cpu_dout", cpu_dout, 16'hBEEF);

    // 2: DMA write leaves cpu_dout alone
    dma_we = 1'b1; dma_addr = 25'h0000040; dma_din = 16'h1234; dma_ds = 2'b01;
    dma_left = 1; dma_req = 1'b1; exp_q.push_back(mk_acc(1'b1));
    run_until_idle(200);
    check("t2_cpu_dout_kept", cpu_dout, 16'hBEEF);

    // 3: simultaneous requests, CPU first
    cpu_we = 1'b1; cpu_addr = 25'h1FFFFFF; cpu_din = 16'hA5A5; cpu_ds = 2'b10;
    dma_we = 1'b0; dma_addr = 25'h0000200; dma_din = 16'h0F0F; dma_ds = 2'b11; dma_rdata = 16'h7E57;
    cpu_left = 1; dma_left = 1; cpu_req = 1'b1; dma_req = 1'b1;
    exp_q.push_back(mk_acc(1'b0));
    exp_q.push_back(mk_acc(1'b1));
    run_until_idle(200);
    check("t3_dma_dout", dma_dout, 16'h7E57);

    // 4: CPU held continuously against a pending DMA read
    cpu_we = 1'b1; cpu_addr = 25'h0001000; cpu_din = 16'hC0DE; cpu_ds = 2'b11;
    dma_addr = 25'h0002000; dma_rdata = 16'hD00D;
    cpu_left = T4_CPU_TOTAL; dma_left = 1; cpu_req = 1'b1; dma_req = 1'b1;
    n = cpu_acks;
    for (int i = 0; i < T4_CPU_TOTAL; i++) begin
      if (i == T4_BEFORE) exp_q.push_back(mk_acc(1'b1));
      exp_q.push_back(mk_acc(1'b0));
    end
    if (T4_BEFORE == T4_CPU_TOTAL) exp_q.push_back(mk_acc(1'b1));
    run_until_idle(1500);
    check("t4_cpu_acks_before_dma", cpu_acks_at_dma - n, T4_BEFORE);
    check("t4_dma_dout", dma_dout, 16'hD00D);

    // 5: reset in the middle of a read slot, request held and restarted
    cpu_we = 1'b0; cpu_addr = 25'h00ABCDE; cpu_din = 16'h1111; cpu_ds = 2'b11; cpu_rdata = 16'h5A5A;
    cpu_left = 1; cpu_req = 1'b1; exp_q.push_back(mk_acc(1'b0));
    n = 0;
    while (!(in_slot && slot_idx == 3) && n < 100) begin
      step();
      n++;
    end
    check("t5_reached_busy3", in_slot && slot_idx == 3, 1);
    RESET_N = 1'b0;
    #1;
    check("t5_rst_bus", bus(), 0);
    check("t5_rst_ports", port_outs(), 0);
    in_slot = 1'b0; cpu_dout_exp = '0; dma_dout_exp = '0;
    exp_q.push_front(cur);
    repeat (3) step();
    RESET_N = 1'b1;
    run_until_idle(200);
    check("t5_cpu_dout", cpu_dout, 16'h5A5A);

    // 6: sync every cycle while the slot is running
    cpu_we = 1'b0; cpu_addr = 25'h0155555; cpu_din = 16'h2222; cpu_ds = 2'b01; cpu_rdata = 16'h3C3C;
    cpu_left = 1; cpu_req = 1'b1; sync_all = 1'b1; exp_q.push_back(mk_acc(1'b0));
    run_until_idle(200);
    repeat (SYNC_PERIOD) step();
    sync_all = 1'b0;
    check("t6_cpu_dout", cpu_dout, 16'h3C3C);
    check("queues_drained", exp_q.size() + ack_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
